// File: rtl/servo_pkg.sv
// Constants and channel state encodings shared by the servo PWM link (tx and rx ends).
package servo_pkg;

  localparam int RESOLUTION = 8;
  localparam int ADDR_W     = 2;
  localparam int BASE_TICKS = 2**RESOLUTION;
  localparam int OVER_LIMIT = 2**(RESOLUTION+1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HIGH     = 2'd1,
    ST_WAIT_LOW = 2'd2
  } chan_state_e;

endpackage

// File: rtl/servo_rx_channel.sv
// One servo input: synchronizer, edge detect, pulse-width FSM and tick-to-position conversion.
module servo_rx_channel
  import servo_pkg::*;
#(
  parameter int Resolution = RESOLUTION
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tick_i,
  input  logic                  in_i,
  output logic                  cap_o,
  output logic [Resolution-1:0] value_o,
  output logic                  err_o
);

  localparam int              CW       = Resolution + 2;
  localparam logic [CW-1:0]   Base     = CW'(2**Resolution);
  localparam logic [CW-1:0]   LastTick = CW'(2**(Resolution+1) - 1);

  logic [1:0]  sync_q;
  logic        prev_q;
  logic [2:0]  vld_pipe_q;
  logic        rise, fall;
  chan_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Edges are only trusted once the sync chain and prev flop hold real samples,
  // so an input already high at reset release is not mistaken for a rising edge.
  assign rise = vld_pipe_q[2] &  sync_q[1] & ~prev_q;
  assign fall = vld_pipe_q[2] & ~sync_q[1] &  prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      vld_pipe_q <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
    end else begin
      sync_q     <= {sync_q[0], in_i};
      prev_q     <= sync_q[1];
      vld_pipe_q <= {vld_pipe_q[1:0], 1'b1};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (rise) begin
        state_d = ST_HIGH;
        cnt_d   = '0;
      end
      ST_HIGH: begin
        if (fall) begin
          state_d = ST_IDLE;
        end else if (tick_i) begin
          if (cnt_q == LastTick) state_d = ST_WAIT_LOW;
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_LOW: if (fall) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cap_o   = (state_q == ST_HIGH) && fall && (cnt_q != '0);
    err_o   = (state_q == ST_HIGH) && !fall && tick_i && (cnt_q == LastTick);
    value_o = (cnt_q < Base) ? '0 : Resolution'(cnt_q - Base);
  end

endmodule

// File: rtl/servo_rx.sv
// Multi-channel servo pulse-width receiver: per-channel decoders feeding a host-readable bank.
module servo_rx
  import servo_pkg::*;
#(
  parameter int Resolution   = RESOLUTION,
  parameter int AddressWidth = ADDR_W,
  parameter int Channels     = 2**AddressWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ce_i,
  input  logic [AddressWidth-1:0] addr_i,
  input  logic                    servoclock_i,
  input  logic [Channels-1:0]     in_i,
  output logic [Resolution-1:0]   data_o,
  output logic [Channels-1:0]     valid_o,
  output logic [Channels-1:0]     error_o
);

  logic [2:0]                           sck_q;
  logic                                 tick;
  logic [Channels-1:0]                  cap, err;
  logic [Channels-1:0][Resolution-1:0]  value;
  logic [Channels-1:0][Resolution-1:0]  bank_q, bank_d;
  logic [Channels-1:0]                  valid_q, valid_d, error_q, error_d;
  logic [Resolution-1:0]                data_q;

  assign tick = sck_q[1] & ~sck_q[2];

  for (genvar g = 0; g < Channels; g++) begin : g_ch
    servo_rx_channel #(.Resolution(Resolution)) u_ch (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .tick_i (tick),
      .in_i   (in_i[g]),
      .cap_o  (cap[g]),
      .value_o(value[g]),
      .err_o  (err[g])
    );
  end

  // A capture overrides a same-cycle read clear so a fresh sample is never lost.
  always_comb begin
    bank_d  = bank_q;
    valid_d = valid_q;
    error_d = error_q | err;
    if (ce_i) valid_d[addr_i] = 1'b0;
    for (int i = 0; i < Channels; i++) begin
      if (cap[i]) begin
        bank_d[i]  = value[i];
        valid_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_q   <= '0;
      bank_q  <= '0;
      valid_q <= '0;
      error_q <= '0;
      data_q  <= '0;
    end else begin
      sck_q   <= {sck_q[1:0], servoclock_i};
      bank_q  <= bank_d;
      valid_q <= valid_d;
      error_q <= error_d;
      data_q  <= bank_q[addr_i];
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign error_o = error_q;

endmodule

// File: tb/tb_servo_rx.sv
// Scoreboard bench for servo_rx: pulses are driven tick by tick, expected positions queued and read back.
module tb_servo_rx;

  localparam int R   = 8;
  localparam int AW  = 2;
  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst, ce, sck;
  logic [AW-1:0]  addr;
  logic [NCH-1:0] in_s;
  logic [R-1:0]   data;
  logic [NCH-1:0] valid, error;

  always #5 clk = ~clk;

  servo_rx #(.Resolution(R), .AddressWidth(AW), .Channels(NCH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ce_i        (ce),
    .addr_i      (addr),
    .servoclock_i(sck),
    .in_i        (in_s),
    .data_o      (data),
    .valid_o     (valid),
    .error_o     (error)
  );

  typedef struct {
    int           ch;
    logic [R-1:0] val;
  } exp_t;

  exp_t         sb[$];
  logic [R-1:0] exp_bank[NCH];
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic tick1();
    sck = 1'b1; cyc(2);
    sck = 1'b0; cyc(2);
  endtask

  task automatic drive_pulse(input int ch, input int n);
    in_s[ch] = 1'b1;
    cyc(2);
    repeat (n) tick1();
    in_s[ch] = 1'b0;
  endtask

  function automatic logic [R-1:0] model(input int n);
    int v;
    v = (n < 256) ? 0 : n - 256;
    return v[R-1:0];
  endfunction

  task automatic pulse_cap(input int ch, input int n, input string tag);
    drive_pulse(ch, n);
    cyc(2);
    chk({tag, "_lat2"}, 32'(valid[ch]), 32'd0);
    cyc(1);
    chk({tag, "_lat3"}, 32'(valid[ch]), 32'd1);
    sb.push_back('{ch, model(n)});
    exp_bank[ch] = model(n);
  endtask

  task automatic drain();
    exp_t e;
    int   k;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      k = 0;
      while (!valid[e.ch] && k < 100) begin cyc(1); k++; end
      chk($sformatf("vld_ch%0d", e.ch), 32'(valid[e.ch]), 32'd1);
      addr = AW'(e.ch);
      cyc(1);
      chk($sformatf("data_ch%0d", e.ch), 32'(data), 32'(e.val));
      ce = 1'b1; cyc(1); ce = 1'b0;
      chk($sformatf("clr_ch%0d", e.ch), 32'(valid[e.ch]), 32'd0);
      chk($sformatf("hold_ch%0d", e.ch), 32'(data), 32'(e.val));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lb[NCH];
    lb = '{0, 'h5A, 'hA5, 'hFF};
    rst = 1'b1; ce = 1'b0; addr = '0; sck = 1'b0; in_s = '0;
    for (int i = 0; i < NCH; i++) exp_bank[i] = '0;

    // reset with toggling inputs, then release in the middle of a pulse on ch0
    repeat (6) begin in_s = NCH'($urandom); cyc(1); end
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    in_s = 4'b0001;
    cyc(3);
    rst = 1'b0;
    cyc(4);
    repeat (20) tick1();
    in_s[0] = 1'b0;
    cyc(6);
    chk("rst_partial", 32'(valid), 32'd0);
    pulse_cap(0, 400, "post_rst");
    drain();

    // nominal and bounds
    addr = 2'd1;
    pulse_cap(1, 356, "nominal");
    drain();
    pulse_cap(0, 256, "base");
    drain();
    pulse_cap(1, 511, "max");
    drain();
    pulse_cap(2, 100, "short");
    drain();
    chk("short_err", 32'(error), 32'd0);
    in_s[0] = 1'b1; cyc(1); in_s[0] = 1'b0;
    cyc(6);
    chk("glitch", 32'(valid), 32'd0);

    // loopback frame as ServoTx would emit it
    in_s = '1;
    cyc(2);
    for (int t = 1; t <= 511; t++) begin
      tick1();
      for (int c = 0; c < NCH; c++) if (t == 256 + lb[c]) in_s[c] = 1'b0;
    end
    cyc(6);
    for (int c = 0; c < NCH; c++) begin
      sb.push_back('{c, R'(lb[c])});
      exp_bank[c] = R'(lb[c]);
    end
    drain();
    chk("loop_err", 32'(error), 32'd0);

    // over-length on ch2
    in_s[2] = 1'b1;
    cyc(2);
    repeat (511) tick1();
    cyc(1);
    chk("ovr_pre", 32'(error), 32'd0);
    tick1();
    cyc(1);
    chk("ovr_err", 32'(error), 32'b0100);
    repeat (88) tick1();
    in_s[2] = 1'b0;
    cyc(6);
    chk("ovr_valid", 32'(valid), 32'd0);
    addr = 2'd2;
    cyc(2);
    chk("ovr_bank", 32'(data), 32'(exp_bank[2]));
    pulse_cap(2, 300, "after_ovr");
    drain();
    chk("sticky_err", 32'(error), 32'b0100);

    // read clear colliding with a capture on ch3
    addr = 2'd3;
    drive_pulse(3, 300);
    cyc(2);
    ce = 1'b1;
    cyc(1);
    ce = 1'b0;
    chk("coll_valid", 32'(valid[3]), 32'd1);
    chk("coll_old", 32'(data), 32'(exp_bank[3]));
    cyc(1);
    chk("coll_new", 32'(data), 32'(model(300)));
    ce = 1'b1; cyc(1); ce = 1'b0;
    chk("coll_clr", 32'(valid[3]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
